// File: rtl/fault_sim_ctrl.sv
// Serial stuck-at fault simulation controller: golden pass, then one pass per fault.
// Optional macro FSIM_FAULT_DROP_EN ends a fault's pass on its first detection.
module fault_sim_ctrl #(
  parameter int N_IN    = 3,
  parameter int N_FAULT = 5,
  parameter int SETTLE  = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      dut_out,
  output logic [N_IN-1:0]           pat_out,
  output logic [N_FAULT-1:0]        fault_en,
  output logic                      busy,
  output logic                      done,
  output logic [N_FAULT-1:0]        detect_map,
  output logic [N_FAULT*N_IN-1:0]   first_pat,
  output logic [$clog2(N_FAULT+1)-1:0] detect_count
);

  localparam int NPAT = 1 << N_IN;
  localparam int FIW  = (N_FAULT > 1) ? $clog2(N_FAULT) : 1;
  localparam int SW   = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int CW   = $clog2(N_FAULT + 1);

  typedef enum logic [1:0] {IDLE, GOLD, FAULT, FIN} state_t;

  state_t              state_reg;
  logic [N_IN-1:0]     pat_reg;
  logic [FIW-1:0]      fidx_reg;
  logic [SW-1:0]       slot_reg;
  logic [N_FAULT-1:0]  fault_en_reg;
  logic                busy_reg;
  logic                done_reg;
  logic [N_FAULT-1:0]  detect_map_reg;
  logic [N_FAULT*N_IN-1:0] first_pat_reg;
  logic [CW-1:0]       detect_count_reg;
  logic                golden_reg [NPAT];

  logic slot_end, pat_last, fault_last, mismatch, new_detect, pass_end, golden_we;

  assign slot_end   = (slot_reg == SW'(SETTLE));
  assign pat_last   = (pat_reg == {N_IN{1'b1}});
  assign fault_last = (fidx_reg == FIW'(N_FAULT - 1));
  assign mismatch   = (dut_out != golden_reg[pat_reg]);
  assign new_detect = mismatch && !detect_map_reg[fidx_reg];
  assign golden_we  = (state_reg == GOLD) && slot_end;

`ifdef FSIM_FAULT_DROP_EN
  assign pass_end = pat_last || new_detect;
`else
  assign pass_end = pat_last;
`endif

  // One register per pattern; written only on the sampling cycle of the golden pass.
  genvar gi;
  generate
    for (gi = 0; gi < NPAT; gi++) begin : g_golden
      always_ff @(posedge clk) begin
        if (rst)
          golden_reg[gi] <= 1'b0;
        else if (golden_we && (pat_reg == N_IN'(gi)))
          golden_reg[gi] <= dut_out;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      pat_reg          <= '0;
      fidx_reg         <= '0;
      slot_reg         <= '0;
      fault_en_reg     <= '0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      detect_map_reg   <= '0;
      first_pat_reg    <= '0;
      detect_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            state_reg        <= GOLD;
            busy_reg         <= 1'b1;
            pat_reg          <= '0;
            fidx_reg         <= '0;
            slot_reg         <= '0;
            fault_en_reg     <= '0;
            detect_map_reg   <= '0;
            first_pat_reg    <= '0;
            detect_count_reg <= '0;
          end
        end
        GOLD: begin
          if (slot_end) begin
            slot_reg <= '0;
            pat_reg  <= pat_reg + N_IN'(1);
            if (pat_last) begin
              state_reg    <= FAULT;
              fidx_reg     <= '0;
              fault_en_reg <= N_FAULT'(1);
            end
          end else begin
            slot_reg <= slot_reg + SW'(1);
          end
        end
        FAULT: begin
          if (slot_end) begin
            slot_reg <= '0;
            if (new_detect) begin
              detect_map_reg[fidx_reg]                      <= 1'b1;
              first_pat_reg[int'(fidx_reg) * N_IN +: N_IN]  <= pat_reg;
              detect_count_reg                              <= detect_count_reg + CW'(1);
            end
            if (pass_end) begin
              pat_reg <= '0;
              if (fault_last) begin
                state_reg    <= FIN;
                busy_reg     <= 1'b0;
                fault_en_reg <= '0;
                done_reg     <= 1'b1;
              end else begin
                fidx_reg     <= fidx_reg + FIW'(1);
                fault_en_reg <= fault_en_reg << 1;
              end
            end else begin
              pat_reg <= pat_reg + N_IN'(1);
            end
          end else begin
            slot_reg <= slot_reg + SW'(1);
          end
        end
        FIN: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign pat_out      = pat_reg;
  assign fault_en     = fault_en_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign detect_map   = detect_map_reg;
  assign first_pat    = first_pat_reg;
  assign detect_count = detect_count_reg;

endmodule

// File: tb/tb_fault_sim_ctrl.sv
// Bench for fault_sim_ctrl: two instances (SETTLE=1 combinational CUT, SETTLE=3 CUT delayed 2 cycles)
// checked against a pattern-level model of the campaign.
module tb_fault_sim_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, start_b = 1'b0;
  logic        dut_out_a, dut_out_b;
  logic [2:0]  pat_a, pat_b;
  logic [4:0]  fen_a, fen_b, map_a, map_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [14:0] first_a, first_b;
  logic [2:0]  cnt_a, cnt_b;

  int checks = 0;
  int failures = 0;
  int sel = 0;
  int mode = 0;
  logic [7:0] rgold = '0;
  logic [7:0] rtab [5];
  int exp_slots [5];

  fault_sim_ctrl #(.N_IN(3), .N_FAULT(5), .SETTLE(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .dut_out(dut_out_a),
    .pat_out(pat_a), .fault_en(fen_a), .busy(busy_a), .done(done_a),
    .detect_map(map_a), .first_pat(first_a), .detect_count(cnt_a));

  fault_sim_ctrl #(.N_IN(3), .N_FAULT(5), .SETTLE(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .dut_out(dut_out_b),
    .pat_out(pat_b), .fault_en(fen_b), .busy(busy_b), .done(done_b),
    .detect_map(map_b), .first_pat(first_b), .detect_count(cnt_b));

  // Mode 0: (a&b)|c with the five fault lines; 1: tied 0; 2: random truth tables.
  function automatic logic cut_resp(input int m, input logic [2:0] p, input logic [4:0] fe);
    logic a, b, c, f;
    if (m == 1) return 1'b0;
    if (m == 2) begin
      for (int i = 0; i < 5; i++)
        if (fe[i]) return rtab[i][p];
      return rgold[p];
    end
    a = p[2]; b = p[1]; c = p[0];
    if (fe[0]) a = 1'b1;
    if (fe[1]) b = 1'b0;
    if (fe[2]) c = 1'b1;
    f = (a & b) | c;
    if (fe[3]) f = 1'b0;
    return f;
  endfunction

  always_comb dut_out_a = cut_resp(mode, pat_a, fen_a);

  logic d1 = 1'b0, d2 = 1'b0;
  always_ff @(posedge clk) begin
    d1 <= cut_resp(mode, pat_b, fen_b);
    d2 <= d1;
  end
  assign dut_out_b = d2;

  logic [2:0]  pat_x, cnt_x;
  logic [4:0]  fen_x, map_x;
  logic [14:0] first_x;
  logic        busy_x, done_x;
  always_comb begin
    pat_x = pat_a; cnt_x = cnt_a; fen_x = fen_a; map_x = map_a;
    first_x = first_a; busy_x = busy_a; done_x = done_a;
    if (sel != 0) begin
      pat_x = pat_b; cnt_x = cnt_b; fen_x = fen_b; map_x = map_b;
      first_x = first_b; busy_x = busy_b; done_x = done_b;
    end
  end

  task automatic compute_exp(input int m, input int settle, output logic [4:0] em,
                             output logic [14:0] ef, output int ec, output int el);
    int slots;
    logic det;
    em = '0; ef = '0; ec = 0; slots = 8;
    for (int f = 0; f < 5; f++) begin
      det = 1'b0;
      exp_slots[f] = 8;
      for (int p = 0; p < 8; p++) begin
        if (!det && cut_resp(m, 3'(p), 5'(1 << f)) != cut_resp(m, 3'(p), 5'd0)) begin
          det = 1'b1;
          em[f] = 1'b1;
          ef[f*3 +: 3] = 3'(p);
          ec++;
`ifdef FSIM_FAULT_DROP_EN
          exp_slots[f] = p + 1;
`endif
        end
      end
      slots += exp_slots[f];
    end
    el = slots * (settle + 1);
  endtask

  task automatic run_check(input int s, input int m, input string tag);
    logic [4:0]  em;
    logic [14:0] ef;
    int ec, el, settle, cyc, got, seqerr;
    logic [4:0] tf[$];
    logic [2:0] tp[$];
    sel = s; mode = m;
    settle = (s == 0) ? 1 : 3;
    compute_exp(m, settle, em, ef, ec, el);
    for (int p = 0; p < 8; p++)
      repeat (settle + 1) begin tf.push_back(5'd0); tp.push_back(3'(p)); end
    for (int f = 0; f < 5; f++)
      for (int p = 0; p < exp_slots[f]; p++)
        repeat (settle + 1) begin tf.push_back(5'(1 << f)); tp.push_back(3'(p)); end
    @(posedge clk); #1;
    if (s == 0) start_a = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    cyc = 0; got = -1; seqerr = 0;
    while (cyc <= el + 20) begin
      if (cyc < el && (busy_x !== 1'b1 || done_x !== 1'b0 || fen_x !== tf[cyc] || pat_x !== tp[cyc]))
        seqerr++;
      if (done_x === 1'b1) begin got = cyc; break; end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (got != el) begin failures++; $display("FAIL %s latency: got %0d want %0d", tag, got, el); end
    checks++;
    if (seqerr != 0) begin failures++; $display("FAIL %s sequence: %0d bad cycles want 0", tag, seqerr); end
    checks++;
    if (map_x !== em) begin failures++; $display("FAIL %s detect_map: got %b want %b", tag, map_x, em); end
    checks++;
    if (first_x !== ef) begin failures++; $display("FAIL %s first_pat: got %h want %h", tag, first_x, ef); end
    checks++;
    if (cnt_x !== 3'(ec)) begin failures++; $display("FAIL %s detect_count: got %0d want %0d", tag, cnt_x, ec); end
    checks++;
    if ({busy_x, fen_x, pat_x} !== 9'd0) begin
      failures++; $display("FAIL %s fin_outputs: got busy=%b fen=%b pat=%0d want 0", tag, busy_x, fen_x, pat_x);
    end
    @(posedge clk); #1;
    checks++;
    if (done_x !== 1'b0 || map_x !== em) begin
      failures++; $display("FAIL %s after_done: got done=%b map=%b want 0/%b", tag, done_x, map_x, em);
    end
    $display("campaign %s dut=%0d lat=%0d map=%b first=%h cnt=%0d", tag, s, got, map_x, first_x, cnt_x);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy_a, done_a, pat_a, fen_a} !== 10'd0) begin
      failures++; $display("FAIL reset_ctrl_a: got %b want 0", {busy_a, done_a, pat_a, fen_a});
    end
    checks++;
    if ({map_a, first_a, cnt_a} !== 23'd0) begin
      failures++; $display("FAIL reset_results_a: got %h want 0", {map_a, first_a, cnt_a});
    end
    checks++;
    if ({busy_b, done_b, pat_b, fen_b, map_b, first_b, cnt_b} !== 33'd0) begin
      failures++; $display("FAIL reset_b: got %h want 0", {busy_b, done_b, pat_b, fen_b, map_b, first_b, cnt_b});
    end
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_reset_mid();
    int ndone;
    sel = 0; mode = 0;
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if ({busy_a, done_a, map_a, cnt_a} !== 10'd0) begin
      failures++; $display("FAIL reset_mid: got busy=%b done=%b map=%b cnt=%0d want 0", busy_a, done_a, map_a, cnt_a);
    end
    ndone = 0;
    repeat (120) begin
      @(posedge clk); #1;
      if (done_a !== 1'b0 || busy_a !== 1'b0) ndone++;
    end
    checks++;
    if (ndone != 0) begin failures++; $display("FAIL reset_mid_quiet: got %0d active cycles want 0", ndone); end
    $display("reset mid-campaign at k+40 done");
    run_check(0, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [4:0]  em;
    logic [14:0] ef;
    int ec, el, cyc, ndone, dc1, dc2;
    sel = 0; mode = 0;
    compute_exp(0, 1, em, ef, ec, el);
    @(posedge clk); #1;
    start_a = 1'b1;
    @(posedge clk); #1;
    cyc = 0; ndone = 0; dc1 = -1; dc2 = -1;
    while (cyc <= 2 * el + 40) begin
      if (done_a === 1'b1) begin
        ndone++;
        if (ndone == 1) dc1 = cyc; else dc2 = cyc;
      end
      if (cyc == el + 1) begin
        checks++;
        if (busy_a !== 1'b0 || map_a !== em) begin
          failures++; $display("FAIL b2b_idle: got busy=%b map=%b want 0/%b", busy_a, map_a, em);
        end
      end
      if (cyc == el + 2) begin
        checks++;
        if (busy_a !== 1'b1 || map_a !== 5'd0 || cnt_a !== 3'd0 || first_a !== 15'd0) begin
          failures++; $display("FAIL b2b_relaunch: got busy=%b map=%b cnt=%0d first=%h want 1/0/0/0", busy_a, map_a, cnt_a, first_a);
        end
      end
      if (ndone == 2) break;
      @(posedge clk); #1;
      cyc++;
    end
    start_a = 1'b0;
    checks++;
    if (dc1 != el) begin failures++; $display("FAIL b2b_done1: got %0d want %0d", dc1, el); end
    checks++;
    if (dc2 != 2 * el + 2) begin failures++; $display("FAIL b2b_done2: got %0d want %0d", dc2, 2 * el + 2); end
    checks++;
    if (map_a !== em || first_a !== ef || cnt_a !== 3'(ec)) begin
      failures++; $display("FAIL b2b_results: got %b/%h/%0d want %b/%h/%0d", map_a, first_a, cnt_a, em, ef, ec);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy_a !== 1'b0) begin failures++; $display("FAIL b2b_stop: got busy=%b want 0", busy_a); end
    $display("back_to_back done1=%0d done2=%0d", dc1, dc2);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      rgold = 8'($urandom);
      for (int i = 0; i < 5; i++) rtab[i] = rgold ^ 8'($urandom & $urandom & $urandom);
      repeat ($urandom_range(0, 5)) @(posedge clk);
      run_check(it % 2, 2, "random");
    end
  endtask

  initial begin
    test_reset();
    run_check(0, 0, "full");
    test_reset_mid();
    test_back_to_back();
    run_check(1, 0, "settle3");
    run_check(0, 1, "tied0");
    run_check(1, 1, "tied0_settle3");
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fault_sim_ctrl.md
Name: fault_sim_ctrl

Overview:
Synthesizable serial-fault simulation controller, the hardware successor to our bench-only stuck-at fault flows.
- Drives an exhaustive test-pattern sweep over N_IN circuit inputs into an external circuit-under-test (CUT) wrapper.
- Runs one golden (fault-free) pass, then one pass per injectable fault, with a one-hot fault-enable per pass.
- Stores the golden response internally and compares each faulty response against it.
- Reports per-fault detection, the first detecting pattern per fault, and the detected-fault count.

Parameters:
N_IN, 3, number of CUT inputs; patterns 0 .. 2^N_IN-1.
N_FAULT, 5, number of injectable faults (one fault-enable line each).
SETTLE, 1, extra cycles a pattern is held before dut_out is sampled (>=0).

Ports:
clk  in  1  system clock.
rst  in  1  reset, synchronous to clk, active-high.
start  in  1  begin a campaign; sampled only in IDLE.
dut_out  in  1  CUT response for the current pat_out/fault_en.
pat_out  out  N_IN  test pattern driven to CUT; {a,b,..} with MSB = first input.
fault_en  out  N_FAULT  one-hot fault injection; all-zero = fault-free.
busy  out  1  campaign in progress.
done  out  1  one-cycle pulse when the campaign completes.
detect_map  out  N_FAULT  bit f = 1 if fault f detected.
first_pat  out  N_FAULT*N_IN  field f = lowest detecting pattern of fault f (0 if undetected).
detect_count  out  $clog2(N_FAULT+1)  number of detected faults.

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, and the golden store is cleared.
- rst mid-campaign aborts the campaign the same cycle: outputs go to 0, no done pulse.
- FSM states: IDLE -> GOLD -> FAULT -> FIN -> IDLE.
- IDLE:
  - start=1 at edge k moves to GOLD.
  - From edge k, busy=1, pat_out=0, fault_en=0.
  - detect_map, first_pat and detect_count clear at edge k.
  - Results otherwise hold from done until the next start.
- Pattern slot:
  - Each slot lasts SETTLE+1 cycles, and pat_out is stable for the whole slot.
  - dut_out is sampled on the last cycle of the slot.
  - pat_out then increments, wrapping from 2^N_IN-1 to 0 at the end of a pass.
- GOLD:
  - Sampled dut_out is written to golden[pat].
  - After pattern 2^N_IN-1, move to FAULT with fault index 0, fault_en = 1<<0, pat_out = 0.
- FAULT, per slot, when the sample != golden[pat]:
  - If detect_map[f] was 0: set detect_map[f], write first_pat[f] = pat, increment detect_count.
  - Later mismatches on the same fault change nothing.
- After the last pattern of a fault:
  - If f < N_FAULT-1: f increments and pat_out returns to 0.
  - Otherwise move to FIN.
- FIN:
  - done=1 for one cycle; busy=0, fault_en=0, pat_out=0.
  - Return to IDLE.
- Latency without the feature: done is high in cycle k + (N_FAULT+1)*2^N_IN*(SETTLE+1).
- start while busy is ignored; start held high in IDLE after FIN launches a new campaign.
- N_FAULT fault passes always run; the golden pass is never skipped.

Optional Feature:
FSIM_FAULT_DROP_EN
- Defined: a fault's pass ends on the slot that first detects it.
  - The next slot begins fault f+1 at pattern 0, or FIN if f was the last fault.
  - Undetected faults still run all 2^N_IN patterns.
  - Latency becomes data-dependent.
- Undefined: full sweep for every fault as above; the detection results are identical in both modes.

Test Plan:
Bench CUT f=(a&b)|c with fault lines 0:a s-a-1, 1:b s-a-0, 2:c s-a-1, 3:f s-a-0, 4:no effect; defaults; start pulsed at edge k.
- Full campaign, no drop:
  - detect_map=5'b01111.
  - first_pat fields f0..f4 = 2,6,0,1,0.
  - detect_count=4.
  - done at k+96.
  - fault_en sequence 0,1,2,4,8,16, each for 16 cycles.
- Same with FSIM_FAULT_DROP_EN: identical results; done at k+58 (slots 8+3+7+1+2+8 = 29).
- Reset mid-campaign: rst at k+40 -> next cycle busy=0, detect_map=0, detect_count=0, and no done pulse. A new start then completes normally with the same results.
- start held high throughout: start pulses during busy are ignored; back-to-back campaigns run, with done at k+96 and again one cycle after FIN, and results re-cleared at each launch.
- SETTLE=3, CUT output registered by 2 cycles: results match the full-campaign test; done at k+192.
- Undetectable-only CUT (dut_out tied 0): detect_map=0, all first_pat=0, detect_count=0, done at k+96.
